// File: rtl/gate_exerciser.sv
// Two-input gate exerciser: steps {a,b} through 00..11, holds each vector
// HOLD_CYCLES cycles, samples dut_o on the last hold cycle and tallies mismatches.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | stepping vectors and sampling dut_o
// DONE  | results valid, waiting for a restart
module gate_exerciser #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       a,
    output logic       b,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] err_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [2:0] op_q;
    logic [1:0] vec;
    logic [7:0] hold;

    logic       expect_bit;
    logic       reserved;
    logic       mismatch;
    logic [1:0] vec_next;

    always_comb begin
        expect_bit = 1'b0;
        reserved   = 1'b0;
        case (op_q)
            3'd0:    expect_bit = vec[1] & vec[0];
            3'd1:    expect_bit = vec[1] | vec[0];
            3'd2:    expect_bit = ~(vec[1] & vec[0]);
            3'd3:    expect_bit = ~(vec[1] | vec[0]);
            3'd4:    expect_bit = vec[1] ^ vec[0];
            3'd5:    expect_bit = ~(vec[1] ^ vec[0]);
            default: reserved   = 1'b1;
        endcase
        // case-inequality so an x or z on dut_o is treated as a failure
        mismatch = reserved || (dut_o !== expect_bit);
        vec_next = vec + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            vec     <= 2'd0;
            hold    <= 8'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= 3'd0;
            err_vec <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= DRIVE;
                        op_q    <= op;
                        vec     <= 2'd0;
                        hold    <= 8'd0;
                        a       <= 1'b0;
                        b       <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        err_cnt <= 3'd0;
                        err_vec <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (hold == HOLD_LAST) begin
                        hold <= 8'd0;
                        if (mismatch) begin
                            err_vec[vec] <= 1'b1;
                            if (err_cnt != 3'd4) begin
                                err_cnt <= err_cnt + 3'd1;
                            end
                        end
                        if (vec == 2'd3) begin
                            // pass must account for the final sample taken on this edge
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == 3'd0) && !mismatch;
                            vec   <= 2'd0;
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            vec <= vec_next;
                            a   <= vec_next[1];
                            b   <= vec_next[0];
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: a behavioural gate model drives dut_o,
// each scenario task checks its own hand-computed results.
module tb_gate_exerciser;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       dut_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] err_vec;

    int         total = 0;
    int         bad = 0;
    int         mode;
    logic [2:0] gate_op;

    gate_exerciser #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .dut_o(dut_o),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .err_vec(err_vec)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input logic [2:0] g, input logic x, input logic y);
        case (g)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            default: return 1'b0;
        endcase
    endfunction

    // mode 0: healthy gate, 1: stuck-at-0, 2: x on vector 2 only
    always_comb begin
        case (mode)
            1:       dut_o = 1'b0;
            2:       dut_o = ({a, b} == 2'b10) ? 1'bx : gate_fn(gate_op, a, b);
            default: dut_o = gate_fn(gate_op, a, b);
        endcase
    end

    // Stimulus only: pulses start, walks cycles after the accept edge,
    // reports the cycle done rose and whether busy/done/{a,b} tracked the vector.
    task automatic run_pass(input logic [2:0] op_in, input int stop_at, input int extra_at,
                            output int done_cyc, output bit seq_ok);
        @(negedge clk);
        op    = op_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = -1;
        seq_ok   = (busy === 1'b1) && (done === 1'b0) && ({a, b} === 2'b00);
        for (int c = 1; c <= stop_at; c++) begin
            @(posedge clk);
            #1;
            start = (c == extra_at) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (!((busy === 1'b1) && (done === 1'b0) && ({a, b} === 2'(c / HOLD))))
                seq_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        mode    = 0;
        gate_op = 3'd3;
        #2;
        total++;
        if ({a, b, busy, done, pass, err_cnt, err_vec} !== 12'd0) begin
            bad++;
            $display("FAIL reset_async: got %b want 0", {a, b, busy, done, pass, err_cnt, err_vec});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a, b, busy, done, pass, err_cnt, err_vec} !== 12'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 0", {a, b, busy, done, pass, err_cnt, err_vec});
        end
    endtask

    task automatic test_good_nor();
        int dc;
        bit ok;
        mode    = 0;
        gate_op = 3'd3;
        run_pass(3'd3, 40, 0, dc, ok);
        total++;
        if (dc != 16) begin bad++; $display("FAIL nor_latency: got %0d want 16", dc); end
        total++;
        if (!ok) begin bad++; $display("FAIL nor_vector_seq: got bad sequence want 00,01,10,11 x4"); end
        total++;
        if ({pass, err_cnt, err_vec} !== 8'b1_000_0000) begin
            bad++;
            $display("FAIL nor_result: got pass=%b cnt=%0d vec=%b want pass=1 cnt=0 vec=0000", pass, err_cnt, err_vec);
        end
        total++;
        if ({busy, a, b} !== 3'b000) begin
            bad++;
            $display("FAIL nor_done_outputs: got busy,a,b=%b want 000", {busy, a, b});
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({done, pass} !== 2'b11) begin
            bad++;
            $display("FAIL done_held: got done,pass=%b want 11", {done, pass});
        end
    endtask

    task automatic test_stuck0();
        int dc;
        bit ok;
        mode    = 1;
        gate_op = 3'd3;
        run_pass(3'd3, 40, 0, dc, ok);
        total++;
        if ({dc == 16, pass, err_cnt, err_vec} !== 9'b1_0_001_0001) begin
            bad++;
            $display("FAIL stuck0: got cyc=%0d pass=%b cnt=%0d vec=%b want cyc=16 pass=0 cnt=1 vec=0001", dc, pass, err_cnt, err_vec);
        end
    endtask

    task automatic test_wrong_gate();
        int dc;
        bit ok;
        mode    = 0;
        gate_op = 3'd1;
        run_pass(3'd0, 40, 0, dc, ok);
        total++;
        if ({dc == 16, pass, err_cnt, err_vec} !== 9'b1_0_010_0110) begin
            bad++;
            $display("FAIL and_vs_or: got cyc=%0d pass=%b cnt=%0d vec=%b want cyc=16 pass=0 cnt=2 vec=0110", dc, pass, err_cnt, err_vec);
        end
    endtask

    task automatic test_x_output();
        int dc;
        bit ok;
        mode    = 2;
        gate_op = 3'd2;
        run_pass(3'd2, 40, 0, dc, ok);
        total++;
        if ({err_vec[2], pass} !== 2'b10) begin
            bad++;
            $display("FAIL x_output: got vec=%b pass=%b want vec[2]=1 pass=0", err_vec, pass);
        end
        mode = 0;
    endtask

    task automatic test_start_busy();
        int dc;
        bit ok;
        mode    = 0;
        gate_op = 3'd3;
        run_pass(3'd3, 40, 5, dc, ok);
        total++;
        if (dc != 16 || !ok) begin
            bad++;
            $display("FAIL start_busy_timing: got cyc=%0d seq=%0d want cyc=16 seq=1", dc, ok);
        end
        total++;
        if ({pass, err_cnt, err_vec} !== 8'b1_000_0000) begin
            bad++;
            $display("FAIL start_busy_result: got pass=%b cnt=%0d vec=%b want 1 0 0000", pass, err_cnt, err_vec);
        end
    endtask

    task automatic test_midpass_reset();
        int dc;
        bit ok;
        mode    = 0;
        gate_op = 3'd3;
        run_pass(3'd3, 9, 0, dc, ok);
        total++;
        if (dc != -1 || !ok) begin
            bad++;
            $display("FAIL pre_reset_seq: got cyc=%0d seq=%0d want cyc=-1 seq=1", dc, ok);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a, b, busy, done, pass, err_cnt, err_vec} !== 12'd0) begin
            bad++;
            $display("FAIL midpass_reset: got %b want 0", {a, b, busy, done, pass, err_cnt, err_vec});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(3'd3, 40, 0, dc, ok);
        total++;
        if (dc != 16 || !ok || {pass, err_cnt, err_vec} !== 8'b1_000_0000) begin
            bad++;
            $display("FAIL after_reset_pass: got cyc=%0d seq=%0d pass=%b cnt=%0d vec=%b want 16 1 1 0 0000", dc, ok, pass, err_cnt, err_vec);
        end
    endtask

    task automatic test_reserved_restart();
        int dc;
        bit ok;
        mode    = 0;
        gate_op = 3'd3;
        run_pass(3'd7, 40, 0, dc, ok);
        total++;
        if ({dc == 16, pass, err_cnt, err_vec} !== 9'b1_0_100_1111) begin
            bad++;
            $display("FAIL reserved_op: got cyc=%0d pass=%b cnt=%0d vec=%b want cyc=16 pass=0 cnt=4 vec=1111", dc, pass, err_cnt, err_vec);
        end
        run_pass(3'd3, 40, 0, dc, ok);
        total++;
        if ({dc == 16, pass, err_cnt, err_vec} !== 9'b1_1_000_0000) begin
            bad++;
            $display("FAIL restart_clean: got cyc=%0d pass=%b cnt=%0d vec=%b want cyc=16 pass=1 cnt=0 vec=0000", dc, pass, err_cnt, err_vec);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_nor();
        test_stuck0();
        test_wrong_gate();
        test_x_output();
        test_start_busy();
        test_midpass_reset();
        test_reserved_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, meaning cycles each input vector is held before the gate output is sampled; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, single-cycle request to run one exercise pass.
REQ-005 The block SHALL have port op, input, 3, gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6..7 reserved.
REQ-006 The block SHALL have port a, output, 1, drives gate input A.
REQ-007 The block SHALL have port b, output, 1, drives gate input B.
REQ-008 The block SHALL have port dut_o, input, 1, gate output being checked.
REQ-009 The block SHALL have port busy, output, 1, high while a pass is in progress.
REQ-010 The block SHALL have port done, output, 1, high after a pass completes, held until the next accepted start or reset.
REQ-011 The block SHALL have port pass, output, 1, valid when done=1; high if no vector mismatched.
REQ-012 The block SHALL have port err_cnt, output, 3, number of mismatching vectors in the last pass, 0..4.
REQ-013 The block SHALL have port err_vec, output, 4, bit i set when vector i ({a,b}=i) mismatched.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, DRIVE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted and SHALL cause the following actions on that edge:
- latch op;
- clear err_cnt, err_vec, done and pass;
- set vec=0 and hold count=0;
- enter DRIVE.
REQ-016 start SHALL be ignored while in DRIVE.
REQ-017 In DRIVE, {a,b} SHALL equal the registered vector index vec (a = vec[1], b = vec[0]), changing only on clock edges.
REQ-018 Each vector SHALL be held for exactly HOLD_CYCLES cycles; the first vector appears the cycle after start is accepted.
REQ-019 dut_o SHALL be sampled only in the last hold cycle of each vector (hold count = HOLD_CYCLES-1).
REQ-020 The sample SHALL be compared against the expected truth-table value for the latched op.
REQ-021 A mismatch SHALL set err_vec[vec] and increment err_cnt.
REQ-022 A dut_o value other than a clean 0 or 1 (x or z, compared by case-equality) SHALL count as a mismatch.
REQ-023 A reserved op SHALL make every vector mismatch: err_cnt=4 and err_vec=4'b1111.
REQ-024 After the sample of vec=3, the FSM SHALL enter DONE on the same edge, with the following outputs:
- busy=0;
- done=1;
- pass=(err_cnt==0), err_cnt including that final sample;
- a and b returned to 0.
REQ-025 Total pass latency from the start-accept edge to done=1 SHALL be 4*HOLD_CYCLES cycles.
REQ-026 busy SHALL be 1 exactly in DRIVE.
REQ-027 The done=1 and busy=1 combination SHALL never occur.
REQ-028 A start accepted in DONE SHALL restart cleanly, with no carry-over of errors.
REQ-029 err_cnt SHALL saturate at 4; it cannot overflow with 4 vectors.
REQ-030 The hold counter SHALL wrap to 0 at each vector change.

Reset
REQ-031 While rst_n=0 the block SHALL hold the following, asynchronously and regardless of clk:
- state=IDLE;
- a=0, b=0;
- busy=0, done=0, pass=0;
- err_cnt=0, err_vec=0;
- vec=0, hold count=0, latched op=0.
REQ-032 Reset asserted mid-pass SHALL abort the pass immediately with no partial results retained.
REQ-033 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 Scenario good NOR: bench SHALL check the response to the following stimulus.
- Stimulus: HOLD_CYCLES=4, op=3, dut_o driven from a correct NOR of a,b, start pulse.
- Required response: {a,b} steps 00,01,10,11, 4 cycles each; done=1 exactly 16 cycles after start; pass=1; err_cnt=0; err_vec=0000.
REQ-035 Scenario stuck-at-0: bench SHALL check the response to the following stimulus.
- Stimulus: op=3, dut_o tied 0.
- Required response: err_vec=0001, err_cnt=1, pass=0.
REQ-036 Scenario wrong gate and x output: bench SHALL check the response to each of the following stimuli.
- Stimulus: op=0 with a correct OR attached. Required response: err_vec=0110, err_cnt=2.
- Stimulus: dut_o=x during vector 2 only. Required response: err_vec bit 2 set.
REQ-037 Scenario start while busy: bench SHALL check the response to the following stimulus.
- Stimulus: second start pulse at cycle 5 of a pass.
- Required response: ignored; done still at cycle 16; results unchanged.
REQ-038 Scenario mid-pass reset: bench SHALL check the response to the following stimulus.
- Stimulus: rst_n low at cycle 9 of a pass.
- Required response: all outputs 0 immediately, without waiting for a clock edge; a new start then yields a normal full 16-cycle pass.
REQ-039 Scenario reserved op and restart: bench SHALL check the response to the following stimulus.
- Stimulus: op=7, start.
- Required response: err_cnt=4, err_vec=1111, pass=0.
- Follow-up: a restart from DONE with op=3 and a good NOR yields pass=1 and err_cnt=0.
